// File: rtl/writeback_refill_ctrl.sv
// Cache miss controller: writes back a dirty victim line, refills it from
// memory, then updates the tag, valid and dirty arrays.
module writeback_refill_ctrl #(
    parameter int TAG_W   = 26,
    parameter int INDEX_W = 2,
    parameter int WSEL_W  = 2,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [TAG_W-1:0]  cpu_tag,
    input  logic [INDEX_W-1:0] cpu_index,
    input  logic              hit,
    input  logic              victim_valid,
    input  logic              victim_dirty,
    input  logic [TAG_W-1:0]  victim_tag,
    input  logic [DATA_W-1:0] line_rdata,
    output logic [WSEL_W-1:0] line_word,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fill_we,
    output logic [DATA_W-1:0] fill_wdata,
    output logic              tag_write,
    output logic              valid_write,
    output logic              dirty_write,
    output logic              dirty_din,
    output logic              stall,
    output logic [15:0]       miss_count,
    output logic [15:0]       wb_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WB     = 2'd1;
    localparam logic [1:0] S_FILL   = 2'd2;
    localparam logic [1:0] S_UPDATE = 2'd3;

    localparam int AW = TAG_W + INDEX_W + WSEL_W + 2;
    localparam logic [WSEL_W-1:0] LAST_WORD = '1;
    localparam logic [15:0] SAT = 16'hFFFF;

    logic [1:0]         state_q, state_d;
    logic [WSEL_W-1:0]  cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [TAG_W-1:0]   vtag_q, vtag_d;
    logic [INDEX_W-1:0] index_q, index_d;
    logic [15:0]        miss_q, miss_d;
    logic [15:0]        wbc_q, wbc_d;
    logic [AW-1:0]      addr;
    logic               miss;

    assign miss       = cpu_req & ~hit;
    assign miss_count = miss_q;
    assign wb_count   = wbc_q;
    assign mem_addr   = 32'(addr);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        vtag_d  = vtag_q;
        index_d = index_q;
        miss_d  = miss_q;
        wbc_d   = wbc_q;
        unique case (state_q)
            S_IDLE: begin
                if (miss) begin
                    tag_d   = cpu_tag;
                    vtag_d  = victim_tag;
                    index_d = cpu_index;
                    cnt_d   = '0;
                    if (miss_q != SAT) miss_d = miss_q + 16'd1;
                    if (victim_valid & victim_dirty) begin
                        state_d = S_WB;
                        if (wbc_q != SAT) wbc_d = wbc_q + 16'd1;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_WB: begin
                if (mem_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        cnt_d   = '0;
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (mem_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) state_d = S_UPDATE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are forced low while reset is held so an abandoned sequence
    // drops its memory request immediately.
    always_comb begin
        line_word   = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr        = '0;
        mem_wdata   = '0;
        fill_we     = 1'b0;
        fill_wdata  = '0;
        tag_write   = 1'b0;
        valid_write = 1'b0;
        dirty_write = 1'b0;
        dirty_din   = 1'b0;
        stall       = 1'b0;
        if (!reset) begin
            unique case (state_q)
                S_IDLE: begin
                    stall = miss;
                    if (cpu_req & hit & cpu_we) begin
                        dirty_write = 1'b1;
                        dirty_din   = 1'b1;
                    end
                end
                S_WB: begin
                    stall     = 1'b1;
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    line_word = cnt_q;
                    addr      = {vtag_q, index_q, cnt_q, 2'b00};
                    mem_wdata = line_rdata;
                end
                S_FILL: begin
                    stall      = 1'b1;
                    mem_req    = 1'b1;
                    line_word  = cnt_q;
                    addr       = {tag_q, index_q, cnt_q, 2'b00};
                    fill_we    = mem_ack;
                    fill_wdata = mem_ack ? mem_rdata : '0;
                end
                default: begin
                    stall       = 1'b1;
                    tag_write   = 1'b1;
                    valid_write = 1'b1;
                    dirty_write = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
            vtag_q  <= '0;
            index_q <= '0;
            miss_q  <= '0;
            wbc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            vtag_q  <= vtag_d;
            index_q <= index_d;
            miss_q  <= miss_d;
            wbc_q   <= wbc_d;
        end
    end

endmodule

// File: tb/tb_writeback_refill_ctrl.sv
// Directed testbench for writeback_refill_ctrl.
module tb_writeback_refill_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, hit;
    logic [25:0] cpu_tag, victim_tag;
    logic [1:0]  cpu_index;
    logic        victim_valid, victim_dirty;
    logic [31:0] line_rdata;
    logic [1:0]  line_word;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        fill_we;
    logic [31:0] fill_wdata;
    logic        tag_write, valid_write, dirty_write, dirty_din, stall;
    logic [15:0] miss_count, wb_count;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // Data-array model: word w of the victim line holds 0xA0 + w.
    assign line_rdata = 32'hA0 + {30'd0, line_word};

    writeback_refill_ctrl dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_tag(cpu_tag), .cpu_index(cpu_index),
        .hit(hit), .victim_valid(victim_valid),
        .victim_dirty(victim_dirty), .victim_tag(victim_tag),
        .line_rdata(line_rdata), .line_word(line_word),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .fill_we(fill_we), .fill_wdata(fill_wdata),
        .tag_write(tag_write), .valid_write(valid_write),
        .dirty_write(dirty_write), .dirty_din(dirty_din),
        .stall(stall), .miss_count(miss_count),
        .wb_count(wb_count)
    );

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; hit = 0;
        cpu_tag = '0; cpu_index = '0;
        victim_valid = 0; victim_dirty = 0;
        victim_tag = '0; mem_ack = 0;
        mem_rdata = '0;
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        cyc();
        cyc();
        tests++;
        if ({mem_req, stall, fill_we, tag_write, dirty_write} !== 5'b0) begin
            failed++;
            $display("FAIL reset_outs got %b exp 00000",
                {mem_req, stall, fill_we, tag_write, dirty_write});
        end
        tests++;
        if ({miss_count, wb_count} !== 32'h0) begin
            failed++;
            $display("FAIL reset_counts got %h exp 0", {miss_count, wb_count});
        end
        reset = 0;
        cyc();
    endtask

    task automatic test_clean_miss();
        logic [31:0] exp_a;
        cpu_req = 1; hit = 0; cpu_we = 0;
        cpu_tag = 26'h123; cpu_index = 2'd1;
        victim_valid = 1; victim_dirty = 0;
        victim_tag = 26'h55; mem_ack = 1;
        #1;
        tests++;
        if ({stall, mem_req} !== 2'b10) begin
            failed++;
            $display("FAIL clean_idle got %b exp 10", {stall, mem_req});
        end
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            cpu_tag = 26'h3FF; cpu_index = 2'd0;
            mem_rdata = 32'h1000 + w;
            #1;
            exp_a = 32'h48D0 + 32'(4 * w);
            tests++;
            if (mem_addr !== exp_a) begin
                failed++;
                $display("FAIL clean_addr%0d got %h exp %h", w, mem_addr, exp_a);
            end
            tests++;
            if ({mem_req, mem_we, fill_we, stall, line_word} !== {4'b1011, 2'(w)}
                || fill_wdata !== 32'h1000 + w) begin
                failed++;
                $display("FAIL clean_fill%0d got %b/%h exp %b/%h", w,
                    {mem_req, mem_we, fill_we, stall, line_word},
                    fill_wdata, {4'b1011, 2'(w)}, 32'h1000 + w);
            end
        end
        cyc();
        tests++;
        if ({tag_write, valid_write, dirty_write, dirty_din, stall, mem_req}
            !== 6'b111010) begin
            failed++;
            $display("FAIL clean_update got %b exp 111010",
                {tag_write, valid_write, dirty_write, dirty_din, stall, mem_req});
        end
        @(negedge clk);
        hit = 1;
        #1;
        tests++;
        if (stall !== 1'b0 || miss_count !== 16'd1 || wb_count !== 16'd0) begin
            failed++;
            $display("FAIL clean_replay got %b/%h/%h exp 0/0001/0000",
                stall, miss_count, wb_count);
        end
        cpu_req = 0; hit = 0;
        cyc();
    endtask

    task automatic test_dirty_miss();
        logic [31:0] exp_a;
        cpu_req = 1; hit = 0; cpu_we = 1;
        cpu_tag = 26'h777; cpu_index = 2'd2;
        victim_valid = 1; victim_dirty = 1;
        victim_tag = 26'h3; mem_ack = 1;
        for (int w = 0; w < 4; w++) begin
            cyc();
            exp_a = 32'hE0 + 32'(4 * w);
            tests++;
            if ({mem_req, mem_we, fill_we} !== 3'b110 || mem_addr !== exp_a
                || mem_wdata !== 32'hA0 + w) begin
                failed++;
                $display("FAIL dirty_wb%0d got %b/%h/%h exp 110/%h/%h", w,
                    {mem_req, mem_we, fill_we}, mem_addr, mem_wdata,
                    exp_a, 32'hA0 + w);
            end
        end
        for (int w = 0; w < 4; w++) begin
            cyc();
            exp_a = 32'h1DDE0 + 32'(4 * w);
            tests++;
            if ({mem_req, mem_we, fill_we} !== 3'b101 || mem_addr !== exp_a) begin
                failed++;
                $display("FAIL dirty_fill%0d got %b/%h exp 101/%h", w,
                    {mem_req, mem_we, fill_we}, mem_addr, exp_a);
            end
        end
        cyc();
        tests++;
        if ({tag_write, dirty_write, dirty_din} !== 3'b110) begin
            failed++;
            $display("FAIL dirty_update got %b exp 110",
                {tag_write, dirty_write, dirty_din});
        end
        @(negedge clk);
        hit = 1;
        #1;
        tests++;
        if ({dirty_write, dirty_din, stall} !== 3'b110
            || wb_count !== 16'd1 || miss_count !== 16'd2) begin
            failed++;
            $display("FAIL dirty_replay got %b/%h/%h exp 110/0001/0002",
                {dirty_write, dirty_din, stall}, wb_count, miss_count);
        end
        cpu_req = 0; hit = 0; cpu_we = 0;
        cyc();
    endtask

    task automatic test_wait_states();
        logic [31:0] exp_a;
        int bad;
        cpu_req = 1; hit = 0; cpu_we = 0;
        cpu_tag = 26'h10; cpu_index = 2'd3;
        victim_valid = 1; victim_dirty = 1;
        victim_tag = 26'h5; mem_ack = 0;
        for (int w = 0; w < 4; w++) begin
            bad = 0;
            exp_a = 32'h170 + 32'(4 * w);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                cpu_req = 0;
                mem_ack = (k == 3);
                #1;
                if ({mem_req, mem_we} !== 2'b11 || mem_addr !== exp_a
                    || mem_wdata !== 32'hA0 + w || line_word !== 2'(w))
                    bad++;
            end
            tests++;
            if (bad != 0) begin
                failed++;
                $display("FAIL wait_word%0d got %h/%h exp %h/%h", w,
                    mem_addr, mem_wdata, exp_a, 32'hA0 + w);
            end
        end
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            mem_ack = 1;
            #1;
            exp_a = 32'h430 + 32'(4 * w);
            tests++;
            if ({mem_req, mem_we} !== 2'b10 || mem_addr !== exp_a) begin
                failed++;
                $display("FAIL wait_fill%0d got %b/%h exp 10/%h", w,
                    {mem_req, mem_we}, mem_addr, exp_a);
            end
        end
        cyc();
        tests++;
        if (tag_write !== 1'b1) begin
            failed++;
            $display("FAIL wait_update got %b exp 1", tag_write);
        end
        cyc();
        tests++;
        if ({wb_count, miss_count} !== {16'd2, 16'd3}) begin
            failed++;
            $display("FAIL wait_counts got %h/%h exp 0002/0003",
                wb_count, miss_count);
        end
    endtask

    task automatic test_write_hit();
        @(negedge clk);
        cpu_req = 1; hit = 1; cpu_we = 1; mem_ack = 1;
        #1;
        tests++;
        if ({dirty_write, dirty_din, stall, mem_req} !== 4'b1100) begin
            failed++;
            $display("FAIL write_hit got %b exp 1100",
                {dirty_write, dirty_din, stall, mem_req});
        end
        cyc();
        tests++;
        if (mem_req !== 1'b0 || miss_count !== 16'd3) begin
            failed++;
            $display("FAIL write_hit_hold got %b/%h exp 0/0003",
                mem_req, miss_count);
        end
        cpu_req = 0; hit = 0; cpu_we = 0;
    endtask

    task automatic test_reset_mid_fill();
        @(negedge clk);
        cpu_req = 1; hit = 0; cpu_tag = 26'h22; cpu_index = 2'd0;
        victim_valid = 0; victim_dirty = 1; mem_ack = 1;
        cyc();
        cpu_req = 0;
        tests++;
        if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h880) begin
            failed++;
            $display("FAIL rst_fill0 got %b/%h exp 10/00000880",
                {mem_req, mem_we}, mem_addr);
        end
        cyc();
        cyc();
        tests++;
        if (mem_req !== 1'b1 || line_word !== 2'd2) begin
            failed++;
            $display("FAIL rst_fill2 got %b/%0d exp 1/2", mem_req, line_word);
        end
        reset = 1;
        #1;
        tests++;
        if ({mem_req, stall, fill_we} !== 3'b000) begin
            failed++;
            $display("FAIL rst_async got %b exp 000", {mem_req, stall, fill_we});
        end
        @(negedge clk);
        reset = 0;
        #1;
        tests++;
        if ({mem_req, stall} !== 2'b00 || miss_count !== 16'd0) begin
            failed++;
            $display("FAIL rst_after got %b/%h exp 00/0000",
                {mem_req, stall}, miss_count);
        end
        cyc();
        tests++;
        if (mem_req !== 1'b0) begin
            failed++;
            $display("FAIL rst_idle got %b exp 0", mem_req);
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        force dut.miss_q = 16'hFFFF;
        #1;
        release dut.miss_q;
        cpu_req = 1; hit = 0; cpu_tag = 26'h1; cpu_index = 2'd1;
        victim_valid = 1; victim_dirty = 0; mem_ack = 1;
        cyc();
        cpu_req = 0;
        tests++;
        if (miss_count !== 16'hFFFF) begin
            failed++;
            $display("FAIL sat_miss got %h exp ffff", miss_count);
        end
        for (int i = 0; i < 5; i++) cyc();
        tests++;
        if (miss_count !== 16'hFFFF || stall !== 1'b0) begin
            failed++;
            $display("FAIL sat_hold got %h/%b exp ffff/0", miss_count, stall);
        end
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_wait_states();
        test_write_hit();
        test_reset_mid_fill();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
